// File: rtl/ge_p1p1_to_p3.sv
// ---------------------------------------------------------------------------
// ge_p1p1_to_p3
//
// Converts a completed point (p1p1: X, Y, Z, T) into extended p3 coordinates
// using one shared, externally supplied field multiplier:
//     r_x = X*T   r_y = Y*Z   r_z = Z*T   r_t = X*Y
// The four products are issued one at a time over a start/done handshake.
// All four results are published on the same edge, and a one-cycle done
// pulse follows that edge. Field elements are routed bit-exact and are never
// interpreted here.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   valid      one-cycle request; p_* sampled on the same edge (IDLE only)
//   p_x..p_t   completed-point coordinates
//   r_x..r_t   p3 result coordinates, held until the next completion/reset
//   done       one-cycle pulse; r_* valid from this cycle
//   mul_a/b    multiplier operands (registered, stable while waiting)
//   mul_start  one-cycle multiplier launch
//   mul_out    multiplier product
//   mul_done   product valid pulse (honoured only in WAIT states)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for valid; operands latched on acceptance
// ISSUEk | mul_start high, mul_a/mul_b present product k's pair
// WAITk  | operands held; mul_done captures product k
//        | pairs: k0 (X,T)  k1 (Y,Z)  k2 (Z,T)  k3 (X,Y)
// ---------------------------------------------------------------------------
module ge_p1p1_to_p3 #(
    parameter int FE_W = 320
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [FE_W-1:0] p_x,
    input  logic [FE_W-1:0] p_y,
    input  logic [FE_W-1:0] p_z,
    input  logic [FE_W-1:0] p_t,
    output logic [FE_W-1:0] r_x,
    output logic [FE_W-1:0] r_y,
    output logic [FE_W-1:0] r_z,
    output logic [FE_W-1:0] r_t,
    output logic            done,
    output logic [FE_W-1:0] mul_a,
    output logic [FE_W-1:0] mul_b,
    output logic            mul_start,
    input  logic [FE_W-1:0] mul_out,
    input  logic            mul_done
);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE0, WAIT0,
        ISSUE1, WAIT1,
        ISSUE2, WAIT2,
        ISSUE3, WAIT3
    } state_t;

    state_t          state, state_nx;

    logic [FE_W-1:0] op_x, op_y, op_z, op_t;
    logic [FE_W-1:0] op_x_nx, op_y_nx, op_z_nx, op_t_nx;
    logic [FE_W-1:0] slot0, slot1, slot2;
    logic [FE_W-1:0] slot0_nx, slot1_nx, slot2_nx;
    logic [FE_W-1:0] r_x_nx, r_y_nx, r_z_nx, r_t_nx;
    logic [FE_W-1:0] mul_a_nx, mul_b_nx;
    logic            mul_start_nx;
    logic            done_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_x      <= '0;
            op_y      <= '0;
            op_z      <= '0;
            op_t      <= '0;
            slot0     <= '0;
            slot1     <= '0;
            slot2     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_t       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            op_x      <= op_x_nx;
            op_y      <= op_y_nx;
            op_z      <= op_z_nx;
            op_t      <= op_t_nx;
            slot0     <= slot0_nx;
            slot1     <= slot1_nx;
            slot2     <= slot2_nx;
            r_x       <= r_x_nx;
            r_y       <= r_y_nx;
            r_z       <= r_z_nx;
            r_t       <= r_t_nx;
            mul_a     <= mul_a_nx;
            mul_b     <= mul_b_nx;
            mul_start <= mul_start_nx;
            done      <= done_nx;
        end
    end

    // Operands and mul_start are loaded on the edge that enters ISSUEk, so
    // the pair is already on mul_a/mul_b for the whole ISSUEk cycle. Entering
    // ISSUE0 uses the ports directly because the operand latches are being
    // written on that same edge.
    always_comb begin
        state_nx     = state;
        op_x_nx      = op_x;
        op_y_nx      = op_y;
        op_z_nx      = op_z;
        op_t_nx      = op_t;
        slot0_nx     = slot0;
        slot1_nx     = slot1;
        slot2_nx     = slot2;
        r_x_nx       = r_x;
        r_y_nx       = r_y;
        r_z_nx       = r_z;
        r_t_nx       = r_t;
        mul_a_nx     = mul_a;
        mul_b_nx     = mul_b;
        mul_start_nx = 1'b0;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (valid) begin
                    op_x_nx      = p_x;
                    op_y_nx      = p_y;
                    op_z_nx      = p_z;
                    op_t_nx      = p_t;
                    mul_a_nx     = p_x;
                    mul_b_nx     = p_t;
                    mul_start_nx = 1'b1;
                    state_nx     = ISSUE0;
                end
            end
            ISSUE0: state_nx = WAIT0;
            ISSUE1: state_nx = WAIT1;
            ISSUE2: state_nx = WAIT2;
            ISSUE3: state_nx = WAIT3;
            WAIT0: begin
                if (mul_done) begin
                    slot0_nx     = mul_out;
                    mul_a_nx     = op_y;
                    mul_b_nx     = op_z;
                    mul_start_nx = 1'b1;
                    state_nx     = ISSUE1;
                end
            end
            WAIT1: begin
                if (mul_done) begin
                    slot1_nx     = mul_out;
                    mul_a_nx     = op_z;
                    mul_b_nx     = op_t;
                    mul_start_nx = 1'b1;
                    state_nx     = ISSUE2;
                end
            end
            WAIT2: begin
                if (mul_done) begin
                    slot2_nx     = mul_out;
                    mul_a_nx     = op_x;
                    mul_b_nx     = op_y;
                    mul_start_nx = 1'b1;
                    state_nx     = ISSUE3;
                end
            end
            WAIT3: begin
                // Last product goes straight to r_t so all four results
                // change on one edge.
                if (mul_done) begin
                    r_x_nx   = slot0;
                    r_y_nx   = slot1;
                    r_z_nx   = slot2;
                    r_t_nx   = mul_out;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ge_p1p1_to_p3.sv
module tb_ge_p1p1_to_p3;
    localparam int FE_W = 320;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid = 1'b0;
    logic [FE_W-1:0] p_x = '0, p_y = '0, p_z = '0, p_t = '0;
    logic [FE_W-1:0] r_x, r_y, r_z, r_t;
    logic            done;
    logic [FE_W-1:0] mul_a, mul_b, mul_out;
    logic            mul_start, mul_done;

    ge_p1p1_to_p3 #(.FE_W(FE_W)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
        .r_x(r_x), .r_y(r_y), .r_z(r_z), .r_t(r_t),
        .done(done),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_out(mul_out), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: product = a + b, done pulse L cycles after start.
    int              cyc = 0;
    int              lat = 1;
    int              m_cnt = 0;
    logic            m_done = 1'b0;
    logic [FE_W-1:0] m_out = '0;
    logic            stray = 1'b0;
    logic [FE_W-1:0] junk;

    assign mul_done = m_done | stray;
    assign mul_out  = stray ? junk : m_out;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_start) begin
            m_out <= mul_a + mul_b;
            if (lat == 1) begin
                m_done <= 1'b1;
                m_cnt  <= 0;
            end else begin
                m_done <= 1'b0;
                m_cnt  <= lat - 1;
            end
        end else if (m_cnt > 0) begin
            m_done <= (m_cnt == 1);
            m_cnt  <= m_cnt - 1;
        end else begin
            m_done <= 1'b0;
        end
    end

    typedef struct {
        logic [FE_W-1:0] a, b;
    } pair_t;
    typedef struct {
        logic [FE_W-1:0] x, y, z, t;
        int              cyc;
    } res_t;

    pair_t pair_q[$];
    res_t  res_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [FE_W-1:0] act, input logic [FE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: operand pairs on mul_start, results on done, operand stability.
    logic            chk_stable = 1'b0;
    logic [FE_W-1:0] la = '0, lb = '0;

    always @(negedge clk) begin
        if (mul_start === 1'b1) begin
            la <= mul_a;
            lb <= mul_b;
            if (pair_q.size() == 0) begin
                chk_int("unexpected_mul_start", 1, 0);
            end else begin
                pair_t p;
                p = pair_q.pop_front();
                chk("mul_a", mul_a, p.a);
                chk("mul_b", mul_b, p.b);
            end
        end else if (chk_stable && (m_cnt > 0 || m_done)) begin
            chk("wait_mul_a_stable", mul_a, la);
            chk("wait_mul_b_stable", mul_b, lb);
        end
        if (done === 1'b1) begin
            if (res_q.size() == 0) begin
                chk_int("unexpected_done", 1, 0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                chk("r_x", r_x, r.x);
                chk("r_y", r_y, r.y);
                chk("r_z", r_z, r.z);
                chk("r_t", r_t, r.t);
                chk_int("done_cycle", cyc, r.cyc);
            end
        end
    end

    // Issue a request at the current negedge; valid is sampled on the next edge.
    task automatic req(input logic [FE_W-1:0] x, y, z, t, input int npairs, input bit exp_res);
        if (npairs > 0) pair_q.push_back('{x, t});
        if (npairs > 1) pair_q.push_back('{y, z});
        if (npairs > 2) pair_q.push_back('{z, t});
        if (npairs > 3) pair_q.push_back('{x, y});
        if (exp_res) res_q.push_back('{x + t, y + z, z + t, x + y, cyc + 1 + 4 * (1 + lat)});
        valid = 1'b1;
        p_x = x; p_y = y; p_z = z; p_t = t;
        @(negedge clk);
        valid = 1'b0;
        p_x = '1; p_y = '1; p_z = '1; p_t = '1;
    endtask

    task automatic wait_done(input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk_int("done_timeout", 0, 1);
    endtask

    initial begin
        junk = {10{32'hDEADBEEF}};

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk("reset_r_x", r_x, '0);
        chk("reset_r_y", r_y, '0);
        chk("reset_r_z", r_z, '0);
        chk("reset_r_t", r_t, '0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_mul_start", int'(mul_start), 0);
        repeat (20) @(negedge clk);

        // Basic, L=1
        lat = 1;
        req(1, 2, 3, 4, 4, 1'b1);
        wait_done(100);
        repeat (3) @(negedge clk);

        // Variable latency, L=3
        lat = 3;
        chk_stable = 1'b1;
        req(1, 2, 3, 4, 4, 1'b1);
        wait_done(100);
        chk_stable = 1'b0;
        repeat (3) @(negedge clk);

        // Busy request ignored, then back-to-back in the done cycle
        lat = 1;
        req(1, 2, 3, 4, 4, 1'b1);
        repeat (3) @(negedge clk);
        valid = 1'b1;
        p_x = 'h10; p_y = 'h20; p_z = 'h30; p_t = 'h40;
        @(negedge clk);
        valid = 1'b0;
        wait_done(100);
        req('h10, 'h20, 'h30, 'h40, 4, 1'b1);
        wait_done(100);
        repeat (3) @(negedge clk);

        // Reset during WAIT2 (L=3)
        lat = 3;
        req(1, 2, 3, 4, 3, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_r_x", r_x, '0);
        chk("midrst_r_y", r_y, '0);
        chk("midrst_r_z", r_z, '0);
        chk("midrst_r_t", r_t, '0);
        chk_int("midrst_mul_start", int'(mul_start), 0);
        chk_int("midrst_done", int'(done), 0);
        repeat (20) @(negedge clk);
        lat = 1;
        req(5, 6, 7, 8, 4, 1'b1);
        wait_done(100);
        repeat (3) @(negedge clk);

        // Stray mul_done in IDLE and in ISSUE1
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        req(1, 2, 3, 4, 4, 1'b1);
        repeat (2) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        wait_done(100);

        repeat (30) @(negedge clk);
        chk_int("pair_queue_empty", pair_q.size(), 0);
        chk_int("result_queue_empty", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ge_p1p1_to_p3.md
Name: ge_p1p1_to_p3

Overview:
- Consumes the completed-point result of the group-element adder (X, Y, Z, T in the p1p1 form) and converts it to extended p3 coordinates: X3=X·T, Y3=Y·Z, Z3=Z·T, T3=X·Y.
- Sits directly downstream of ge_add in the Ed25519 point-arithmetic datapath.
- Does no field arithmetic itself. It sequences the four products through one shared field multiplier over a start/done handshake, then presents all four results together.

Parameters:
- FE_W, 320, field element width: 10 limbs × 32-bit signed, passed through opaquely.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- valid  in  1  one-cycle request; p_* sampled on the same edge
- p_x  in  FE_W  completed-point X
- p_y  in  FE_W  completed-point Y
- p_z  in  FE_W  completed-point Z
- p_t  in  FE_W  completed-point T
- r_x  out  FE_W  p3 X = X·T
- r_y  out  FE_W  p3 Y = Y·Z
- r_z  out  FE_W  p3 Z = Z·T
- r_t  out  FE_W  p3 T = X·Y
- done  out  1  one-cycle pulse; r_* valid from this cycle
- mul_a  out  FE_W  multiplier operand A
- mul_b  out  FE_W  multiplier operand B
- mul_start  out  1  one-cycle multiplier launch
- mul_out  in  FE_W  multiplier product
- mul_done  in  1  product valid, one-cycle pulse

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-low (rst=0 sampled on a rising edge resets).
- Reset values: r_x/r_y/r_z/r_t=0, done=0, mul_start=0, mul_a=0, mul_b=0, state IDLE, operand latches 0.
- States: IDLE, ISSUE0..3, WAIT0..3.
- IDLE + valid=1: latch p_x/p_y/p_z/p_t into internal registers, go to ISSUE0. The input ports may change afterwards.
- ISSUEk:
  - mul_a/mul_b are registered and drive the pair for product k.
  - Pairs: k=0 (X,T), k=1 (Y,Z), k=2 (Z,T), k=3 (X,Y).
  - mul_start=1 for exactly this cycle; next state WAITk.
- WAITk:
  - mul_a/mul_b are held stable and mul_start=0.
  - On mul_done=1, capture mul_out into slot k.
  - Next state is ISSUEk+1, or IDLE after k=3.
- Output update: r_x/r_y/r_z are written from their slots and r_t from mul_out on the WAIT3 capture edge, all four simultaneously. done=1 for the following cycle only.
- Hold: r_* hold their previous values until that edge, and keep their new values until the next completion or reset.
- Latency: with the multiplier asserting mul_done L cycles after mul_start (L≥1), done rises 4·(1+L) edges after the valid edge. For L=1 that is 8 edges.
- valid while not in IDLE: ignored, with no queuing and no effect on the latched operands.
- valid in the same cycle as done (state IDLE): accepted normally, which gives back-to-back operation.
- mul_done in IDLE or in any ISSUE state: ignored.
- mul_out when mul_done=0: ignored.
- Reset mid-operation: abort immediately. State goes to IDLE, mul_start=0, no done pulse, r_* cleared to 0. A multiplier done arriving after reset is ignored.
- No arithmetic on data: values are routed bit-exact, with no width change.

Test Plan (bench multiplier model: mul_out = mul_a + mul_b mod 2^320, mul_done L cycles after mul_start):
- Reset check: hold rst=0 for 2 edges, then rst=1. Require r_* = 0, done=0, mul_start=0; no mul_start while valid stays 0 for 20 cycles.
- Basic conversion, L=1:
  - Stimulus: p_x=1, p_y=2, p_z=3, p_t=4, valid pulsed.
  - Operand pairs in order (1,4), (2,3), (3,4), (1,2), with four single-cycle mul_start pulses.
  - done on edge 8; r_x=5, r_y=5, r_z=7, r_t=3.
- Variable latency, L=3, same inputs: done on edge 16 with identical r_*. mul_a/mul_b are stable throughout each WAIT.
- Busy and back-to-back:
  - Pulse valid again with p_x=0x10 mid-run: ignored, first results unchanged.
  - Then pulse valid in the done cycle with p_x=0x10, p_y=0x20, p_z=0x30, p_t=0x40: second done, r_x=0x50, r_y=0x50, r_z=0x70, r_t=0x30.
- Reset mid-op: assert rst=0 during WAIT2. Require no done, r_*=0, mul_start=0. A late mul_done is ignored, and a following request completes correctly.
- Stray handshake: pulse mul_done in IDLE and in ISSUE1. No state change or capture occurs, and the results equal the basic case.
